instruction_decode_stage: RTL and testbench

- Parametrised MIPS ID stage between the IF/ID register and EX.
- Contains the register file, a per-register pending-write scoreboard and the control decode.
- Resolves beq/bne in ID and computes the branch target.
- Drives a valid/ready ID/EX output register with stall and flush handling.
- Generalises the single-cycle decode to configurable width and register count, with multi-write scoreboarding and back-pressure.

---
 rtl/id_pkg.sv | 38 +++
 rtl/instruction_decode_stage_if.sv | 46 ++++
 rtl/id_scoreboard.sv | 54 +++++
 rtl/instruction_decode_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_instruction_decode_stage.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// Shared encodings for the MIPS instruction decode stage: opcodes, R-type
// function codes, ALU control codes and the decoded control bundle.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // reg_dst selects rd (R-type) over rt as the destination index.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Bundle of the fetch-side, writeback-side and ID/EX-side signals of the
// decode stage. The slave modport is the stage itself; master is its
// surrounding pipeline (fetch, EX and writeback).
interface instruction_decode_stage_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc4;
  logic            id_ready;
  logic            ex_ready;
  logic            wb_we;
  logic [RAW-1:0]  wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid;
  logic [XLEN-1:0] ex_rs_data;
  logic [XLEN-1:0] ex_rt_data;
  logic [XLEN-1:0] ex_imm;
  logic [RAW-1:0]  ex_rs;
  logic [RAW-1:0]  ex_rt;
  logic [RAW-1:0]  ex_dst;
  logic [3:0]      ex_alu_ctrl;
  logic            ex_alu_src;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_mem_to_reg;
  logic            pc_src;
  logic [XLEN-1:0] pc_target;
  logic            flush_if;

  modport master (
    output if_valid, if_instr, if_pc4, ex_ready, wb_we, wb_addr, wb_data,
    input  id_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
           ex_dst, ex_alu_ctrl, ex_alu_src, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, pc_src, pc_target, flush_if
  );

  modport slave (
    input  if_valid, if_instr, if_pc4, ex_ready, wb_we, wb_addr, wb_data,
    output id_ready, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt,
           ex_dst, ex_alu_ctrl, ex_alu_src, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, pc_src, pc_target, flush_if
  );
endinterface

// File: rtl/id_scoreboard.sv
// Per-register in-flight write counters. A source is busy while its counter
// is nonzero, except when the last outstanding write is landing this very
// cycle (the register file forwards it). The destination query reports a
// counter that cannot take another increment.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int RAW    = 5,
  parameter int PEND_W = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           inc,
  input  logic [RAW-1:0] inc_addr,
  input  logic           dec,
  input  logic [RAW-1:0] dec_addr,
  input  logic [RAW-1:0] rs_q,
  input  logic [RAW-1:0] rt_q,
  input  logic [RAW-1:0] dst_q,
  output logic           rs_busy,
  output logic           rt_busy,
  output logic           dst_sat
);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] cnt [NREG];

  function automatic logic src_busy(input logic [PEND_W-1:0] c,
                                    input logic [RAW-1:0]    a);
    return (c != '0) && !((c == CNT_ONE) && dec && (dec_addr == a));
  endfunction

  assign rs_busy = src_busy(cnt[rs_q], rs_q);
  assign rt_busy = src_busy(cnt[rt_q], rt_q);
  assign dst_sat = (cnt[dst_q] == CNT_MAX);

  // Counter update: r0 is never tracked; simultaneous inc/dec cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (inc && (inc_addr == RAW'(i)) && !(dec && (dec_addr == RAW'(i))))
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec && (dec_addr == RAW'(i)) && !(inc && (inc_addr == RAW'(i)))
                 && (cnt[i] != '0))
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: register file, pending-write scoreboard, control decode,
// beq/bne resolution and a valid/ready ID/EX register.
// Optional build macro ID_JUMP_EN: when defined, opcode 2 (j) redirects
// fetch from ID; otherwise it decodes as a NOP.
module instruction_decode_stage
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int RAW    = 5,
  parameter int PEND_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_decode_stage_if.slave bus
);

  function automatic logic signed [XLEN-1:0] sext16(input logic [15:0] v);
    return XLEN'(signed'(v));
  endfunction

  logic [XLEN-1:0]        rf [NREG];
  logic [5:0]             opcode_p0, funct_p0;
  logic [RAW-1:0]         rs_a_p0, rt_a_p0, rd_a_p0, dst_a_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [XLEN-1:0]        rs_val_p0, rt_val_p0, target_p0;
  ctrl_t                  ctrl_p0;
  logic                   rtype_ok, use_rs_p0, use_rt_p0;
  logic                   is_beq_p0, is_bne_p0, is_j_p0;
  logic                   dst_wr_p0, wb_wr, hazard_p0, ready_p0, accept_p0;
  logic                   br_taken_p0, taken_p0;
  logic                   rs_busy, rt_busy, dst_sat;

  logic                   vld_p1;
  logic [XLEN-1:0]        rs_data_p1, rt_data_p1, imm_p1;
  logic [RAW-1:0]         rs_p1, rt_p1, dst_p1;
  logic [3:0]             alu_ctrl_p1;
  logic                   alu_src_p1, reg_write_p1, mem_read_p1;
  logic                   mem_write_p1, mem_to_reg_p1;

  assign opcode_p0 = bus.if_instr[31:26];
  assign funct_p0  = bus.if_instr[5:0];
  assign rs_a_p0   = RAW'(bus.if_instr[25:21]);
  assign rt_a_p0   = RAW'(bus.if_instr[20:16]);
  assign rd_a_p0   = RAW'(bus.if_instr[15:11]);
  assign imm_p0    = sext16(bus.if_instr[15:0]);
  assign wb_wr     = bus.wb_we && (bus.wb_addr != '0) && !reset;

  // Register file write port; r0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_wr) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Write-first read ports: a same-cycle writeback is forwarded.
  always_comb begin
    rs_val_p0 = rf[rs_a_p0];
    rt_val_p0 = rf[rt_a_p0];
    if (rs_a_p0 == '0)                              rs_val_p0 = '0;
    else if (wb_wr && (bus.wb_addr == rs_a_p0))     rs_val_p0 = bus.wb_data;
    if (rt_a_p0 == '0)                              rt_val_p0 = '0;
    else if (wb_wr && (bus.wb_addr == rt_a_p0))     rt_val_p0 = bus.wb_data;
  end

  // Control decode; anything unrecognised leaves the NOP defaults.
  always_comb begin
    ctrl_p0   = CTRL_NOP;
    rtype_ok  = 1'b0;
    use_rs_p0 = 1'b0;
    use_rt_p0 = 1'b0;
    is_beq_p0 = 1'b0;
    is_bne_p0 = 1'b0;
    is_j_p0   = 1'b0;
    case (opcode_p0)
      OP_RTYPE: begin
        rtype_ok = 1'b1;
        case (funct_p0)
          FN_ADD:  ctrl_p0.alu_ctrl = ALU_ADD;
          FN_SUB:  ctrl_p0.alu_ctrl = ALU_SUB;
          FN_AND:  ctrl_p0.alu_ctrl = ALU_AND;
          FN_OR:   ctrl_p0.alu_ctrl = ALU_OR;
          FN_SLT:  ctrl_p0.alu_ctrl = ALU_SLT;
          default: rtype_ok = 1'b0;
        endcase
        if (rtype_ok) begin
          ctrl_p0.reg_dst   = 1'b1;
          ctrl_p0.reg_write = 1'b1;
          use_rs_p0         = 1'b1;
          use_rt_p0         = 1'b1;
        end
      end
      OP_LW: begin
        ctrl_p0.alu_src    = 1'b1;
        ctrl_p0.reg_write  = 1'b1;
        ctrl_p0.mem_read   = 1'b1;
        ctrl_p0.mem_to_reg = 1'b1;
        ctrl_p0.alu_ctrl   = ALU_ADD;
        use_rs_p0          = 1'b1;
      end
      OP_ADDI: begin
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_ctrl  = ALU_ADD;
        use_rs_p0         = 1'b1;
      end
      OP_SW: begin
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.mem_write = 1'b1;
        ctrl_p0.alu_ctrl  = ALU_ADD;
        use_rs_p0         = 1'b1;
        use_rt_p0         = 1'b1;
      end
      OP_BEQ: begin
        is_beq_p0 = 1'b1;
        use_rs_p0 = 1'b1;
        use_rt_p0 = 1'b1;
      end
      OP_BNE: begin
        is_bne_p0 = 1'b1;
        use_rs_p0 = 1'b1;
        use_rt_p0 = 1'b1;
      end
`ifdef ID_JUMP_EN
      OP_J: is_j_p0 = 1'b1;
`endif
      default: ;
    endcase
  end

  assign dst_a_p0  = ctrl_p0.reg_dst ? rd_a_p0 : rt_a_p0;
  assign dst_wr_p0 = ctrl_p0.reg_write && (dst_a_p0 != '0);

  id_scoreboard #(
    .NREG   (NREG),
    .RAW    (RAW),
    .PEND_W (PEND_W)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .inc      (accept_p0 && dst_wr_p0),
    .inc_addr (dst_a_p0),
    .dec      (wb_wr),
    .dec_addr (bus.wb_addr),
    .rs_q     (rs_a_p0),
    .rt_q     (rt_a_p0),
    .dst_q    (dst_a_p0),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .dst_sat  (dst_sat)
  );

  assign hazard_p0   = (use_rs_p0 && rs_busy) || (use_rt_p0 && rt_busy) ||
                       (dst_wr_p0 && dst_sat);
  assign ready_p0    = !reset && !hazard_p0 && !(vld_p1 && !bus.ex_ready);
  assign accept_p0   = bus.if_valid && ready_p0;
  assign br_taken_p0 = accept_p0 &&
                       ((is_beq_p0 && (rs_val_p0 == rt_val_p0)) ||
                        (is_bne_p0 && (rs_val_p0 != rt_val_p0)));
  assign taken_p0    = br_taken_p0 || (accept_p0 && is_j_p0);

  // Redirect address for a taken branch (or jump when enabled).
  always_comb begin
    target_p0 = '0;
    if (br_taken_p0) target_p0 = bus.if_pc4 + XLEN'(imm_p0 <<< 2);
`ifdef ID_JUMP_EN
    if (accept_p0 && is_j_p0)
      target_p0 = {bus.if_pc4[XLEN-1:28], bus.if_instr[25:0], 2'b00};
`endif
  end

  assign bus.id_ready  = ready_p0;
  assign bus.pc_src    = taken_p0;
  assign bus.flush_if  = taken_p0;
  assign bus.pc_target = target_p0;

  // ---- ID / EX boundary ----
  // ID/EX register: load on accept, hold under back-pressure, drain otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      dst_p1        <= '0;
      alu_ctrl_p1   <= '0;
      alu_src_p1    <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1        <= 1'b1;
      rs_data_p1    <= rs_val_p0;
      rt_data_p1    <= rt_val_p0;
      imm_p1        <= imm_p0;
      rs_p1         <= rs_a_p0;
      rt_p1         <= rt_a_p0;
      dst_p1        <= ctrl_p0.reg_write ? dst_a_p0 : '0;
      alu_ctrl_p1   <= ctrl_p0.alu_ctrl;
      alu_src_p1    <= ctrl_p0.alu_src;
      reg_write_p1  <= ctrl_p0.reg_write;
      mem_read_p1   <= ctrl_p0.mem_read;
      mem_write_p1  <= ctrl_p0.mem_write;
      mem_to_reg_p1 <= ctrl_p0.mem_to_reg;
    end else if (bus.ex_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.ex_valid      = vld_p1;
  assign bus.ex_rs_data    = rs_data_p1;
  assign bus.ex_rt_data    = rt_data_p1;
  assign bus.ex_imm        = imm_p1;
  assign bus.ex_rs         = rs_p1;
  assign bus.ex_rt         = rt_p1;
  assign bus.ex_dst        = dst_p1;
  assign bus.ex_alu_ctrl   = alu_ctrl_p1;
  assign bus.ex_alu_src    = alu_src_p1;
  assign bus.ex_reg_write  = reg_write_p1;
  assign bus.ex_mem_read   = mem_read_p1;
  assign bus.ex_mem_write  = mem_write_p1;
  assign bus.ex_mem_to_reg = mem_to_reg_p1;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage with a scoreboard queue of
// expected ID/EX transfers popped by an independent monitor.
module tb_instruction_decode_stage;
  import id_pkg::*;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int RAW    = 5;
  localparam int PEND_W = 1;

  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [3:0]  alu;
    logic [4:0]  c;  // {alu_src, reg_write, mem_read, mem_write, mem_to_reg}
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t expq[$];
  exp_t mon_act, mon_exp;

  always #5 clk = ~clk;

  instruction_decode_stage_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

  instruction_decode_stage #(
    .XLEN(XLEN), .NREG(NREG), .RAW(RAW), .PEND_W(PEND_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [31:0] imm, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] dst,
                              input logic [3:0] alu, input logic [4:0] c);
    exp_t e;
    e.rs_data = rsd; e.rt_data = rtd; e.imm = imm;
    e.rs = rs; e.rt = rt; e.dst = dst; e.alu = alu; e.c = c;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc4   = pc4;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.wb_we   = we;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  // Monitor: every ID/EX transfer to EX is matched against the queue head.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
      mon_act.rs_data = bus.ex_rs_data;
      mon_act.rt_data = bus.ex_rt_data;
      mon_act.imm     = bus.ex_imm;
      mon_act.rs      = bus.ex_rs;
      mon_act.rt      = bus.ex_rt;
      mon_act.dst     = bus.ex_dst;
      mon_act.alu     = bus.ex_alu_ctrl;
      mon_act.c       = {bus.ex_alu_src, bus.ex_reg_write, bus.ex_mem_read,
                         bus.ex_mem_write, bus.ex_mem_to_reg};
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL idex_unexpected actual=%h required=no_transfer", mon_act);
      end else begin
        mon_exp = expq.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL idex_transfer actual=%h required=%h", mon_act, mon_exp);
        end
      end
    end
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    bus.ex_ready = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_ex_rs_data", bus.ex_rs_data, 0);
    check("rst_ex_imm", bus.ex_imm, 0);
    check("rst_pc_src", bus.pc_src, 0);
    check("rst_flush_if", bus.flush_if, 0);
    check("rst_id_ready", bus.id_ready, 1);
    tick();

    // addi r1,r0,5 then add r2,r1,r1 released by same-cycle writeback
    drive(1'b1, itype(OP_ADDI, 5'd0, 5'd1, 16'd5), 32'h4);
    expq.push_back(mk(32'd0, 32'd0, 32'd5, 5'd0, 5'd1, 5'd1, ALU_ADD, 5'b11000));
    @(negedge clk); check("addi_ready", bus.id_ready, 1);
    tick();
    drive(1'b1, rtype(5'd1, 5'd1, 5'd2, FN_ADD), 32'h8);
    @(negedge clk); check("add_stall_c1", bus.id_ready, 0);
    tick();
    @(negedge clk); check("add_stall_c2", bus.id_ready, 0);
    tick();
    wb(1'b1, 5'd1, 32'd5);
    expq.push_back(mk(32'd5, 32'd5, 32'h1020, 5'd1, 5'd1, 5'd2, ALU_ADD, 5'b01000));
    @(negedge clk); check("add_release_ready", bus.id_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b1, 5'd2, 32'd10);
    tick();
    wb(1'b0, 5'd0, 32'h0);

    // Two lw r3 with a one-deep counter: second waits for the first writeback
    drive(1'b1, itype(OP_LW, 5'd0, 5'd3, 16'd0), 32'h10);
    expq.push_back(mk(32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3, ALU_ADD, 5'b11101));
    @(negedge clk); check("lw1_ready", bus.id_ready, 1);
    tick();
    @(negedge clk); check("lw2_stall_c1", bus.id_ready, 0);
    tick();
    @(negedge clk); check("lw2_stall_c2", bus.id_ready, 0);
    tick();
    wb(1'b1, 5'd3, 32'h33);
    @(negedge clk); check("lw2_stall_wb", bus.id_ready, 0);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    expq.push_back(mk(32'd0, 32'h33, 32'd0, 5'd0, 5'd3, 5'd3, ALU_ADD, 5'b11101));
    @(negedge clk); check("lw2_ready", bus.id_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b1, 5'd3, 32'h33);
    tick();

    // Branches with r4 = r5 = 7
    wb(1'b1, 5'd4, 32'd7);
    tick();
    wb(1'b1, 5'd5, 32'd7);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, itype(OP_BEQ, 5'd4, 5'd5, 16'd3), 32'h100);
    expq.push_back(mk(32'd7, 32'd7, 32'd3, 5'd4, 5'd5, 5'd0, 4'b0000, 5'b00000));
    @(negedge clk);
    check("beq_ready", bus.id_ready, 1);
    check("beq_pc_src", bus.pc_src, 1);
    check("beq_pc_target", bus.pc_target, 32'h10C);
    check("beq_flush_if", bus.flush_if, 1);
    tick();
    drive(1'b1, itype(OP_BNE, 5'd4, 5'd5, 16'd3), 32'h100);
    expq.push_back(mk(32'd7, 32'd7, 32'd3, 5'd4, 5'd5, 5'd0, 4'b0000, 5'b00000));
    @(negedge clk);
    check("beq_ex_valid", bus.ex_valid, 1);
    check("beq_ex_reg_write", bus.ex_reg_write, 0);
    check("bne_eq_pc_src", bus.pc_src, 0);
    check("bne_eq_flush_if", bus.flush_if, 0);
    tick();
    drive(1'b1, itype(OP_BNE, 5'd4, 5'd0, 16'hFFFF), 32'h200);
    expq.push_back(mk(32'd7, 32'd0, 32'hFFFF_FFFF, 5'd4, 5'd0, 5'd0, 4'b0000, 5'b00000));
    @(negedge clk);
    check("bne_neg_pc_src", bus.pc_src, 1);
    check("bne_neg_pc_target", bus.pc_target, 32'h1FC);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Back-pressure: sw held in ID/EX for four cycles
    bus.ex_ready = 1'b0;
    drive(1'b1, itype(OP_SW, 5'd5, 5'd4, 16'd8), 32'h300);
    expq.push_back(mk(32'd7, 32'd7, 32'd8, 5'd5, 5'd4, 5'd0, ALU_ADD, 5'b10010));
    @(negedge clk); check("sw_ready", bus.id_ready, 1);
    tick();
    drive(1'b1, itype(OP_ADDI, 5'd0, 5'd6, 16'd9), 32'h304);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_id_ready", bus.id_ready, 0);
      check("bp_ex_valid", bus.ex_valid, 1);
      check("bp_ex_imm", bus.ex_imm, 32'd8);
      check("bp_ex_mem_write", bus.ex_mem_write, 1);
      tick();
    end
    bus.ex_ready = 1'b1;
    expq.push_back(mk(32'd0, 32'd0, 32'd9, 5'd0, 5'd6, 5'd6, ALU_ADD, 5'b11000));
    @(negedge clk); check("bp_release_ready", bus.id_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("bp_next_valid", bus.ex_valid, 1);
    check("bp_next_dst", bus.ex_dst, 6);
    tick();
    wb(1'b1, 5'd6, 32'd9);
    tick();

    // r0: writeback ignored, forwarding never applies, no tracking
    drive(1'b1, rtype(5'd0, 5'd0, 5'd7, FN_ADD), 32'h400);
    wb(1'b1, 5'd0, 32'hFFFF);
    expq.push_back(mk(32'd0, 32'd0, 32'h3820, 5'd0, 5'd0, 5'd7, ALU_ADD, 5'b01000));
    @(negedge clk); check("r0_wb_ready", bus.id_ready, 1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, itype(OP_ADDI, 5'd0, 5'd0, 16'd1), 32'h404);
    expq.push_back(mk(32'd0, 32'd0, 32'd1, 5'd0, 5'd0, 5'd0, ALU_ADD, 5'b11000));
    @(negedge clk); check("addi_r0_ready", bus.id_ready, 1);
    tick();
    drive(1'b1, rtype(5'd0, 5'd0, 5'd8, FN_ADD), 32'h408);
    expq.push_back(mk(32'd0, 32'd0, 32'h4020, 5'd0, 5'd0, 5'd8, ALU_ADD, 5'b01000));
    @(negedge clk); check("r0_no_stall", bus.id_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    wb(1'b1, 5'd7, 32'd0);
    tick();
    wb(1'b1, 5'd8, 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);

    // j 0x40 at pc4 0x104
    drive(1'b1, {6'd2, 26'h40}, 32'h104);
    expq.push_back(mk(32'd0, 32'd0, 32'h40, 5'd0, 5'd0, 5'd0, 4'b0000, 5'b00000));
    @(negedge clk);
`ifdef ID_JUMP_EN
    check("j_pc_src", bus.pc_src, 1);
    check("j_pc_target", bus.pc_target, 32'h100);
    check("j_flush_if", bus.flush_if, 1);
`else
    check("j_pc_src", bus.pc_src, 0);
    check("j_flush_if", bus.flush_if, 0);
`endif
    tick();

    // Reset during a stall discards the pending write of r9
    drive(1'b1, itype(OP_LW, 5'd0, 5'd9, 16'd0), 32'h500);
    expq.push_back(mk(32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd9, ALU_ADD, 5'b11101));
    @(negedge clk); check("lw9_ready", bus.id_ready, 1);
    tick();
    drive(1'b1, rtype(5'd9, 5'd0, 5'd10, FN_ADD), 32'h504);
    @(negedge clk); check("add_r9_stall", bus.id_ready, 0);
    tick();
    reset = 1'b1;
    wb(1'b1, 5'd9, 32'h99);
    @(negedge clk);
    check("in_reset_ready", bus.id_ready, 0);
    check("in_reset_pc_src", bus.pc_src, 0);
    tick();
    reset = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    expq.push_back(mk(32'd0, 32'd0, 32'h5020, 5'd9, 5'd0, 5'd10, ALU_ADD, 5'b01000));
    @(negedge clk);
    check("post_reset_ex_valid", bus.ex_valid, 0);
    check("post_reset_ready", bus.id_ready, 1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    repeat (3) tick();

    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
